// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter and the cube clock divider.
package clock_period_meter_pkg;

  // Counter width shared with the divider so both agree on the count range.
  localparam int CNT_W_DEFAULT = 28;

  // Cycles without a strobe edge before the meter flags a stall.
  localparam int TIMEOUT_DEFAULT = 1_000_000;

  // Cube refresh timing: the divider toggles its strobe every REFRESH_HALF_CYCLES
  // system clocks, so a healthy meter reads these values back.
  localparam int REFRESH_HALF_CYCLES = 150_001;
  localparam int REFRESH_FULL_CYCLES = 2 * REFRESH_HALF_CYCLES;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_t;

endpackage

// File: rtl/clock_period_meter_if.sv
// Measurement bundle between the strobe source/readback side and the meter.
interface clock_period_meter_if #(
  parameter int CNT_W = 28
);
  logic             sig_in;
  logic             enable;
  logic [CNT_W-1:0] half_period;
  logic [CNT_W:0]   full_period;
  logic             meas_valid;
  logic             full_valid;
  logic             stalled;

  modport master (
    output sig_in,
    output enable,
    input  half_period,
    input  full_period,
    input  meas_valid,
    input  full_valid,
    input  stalled
  );

  modport slave (
    input  sig_in,
    input  enable,
    output half_period,
    output full_period,
    output meas_valid,
    output full_valid,
    output stalled
  );
endinterface

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Synchronizer for an asynchronous input plus a both-edge detector.
// The chain runs continuously so edge latency is fixed at SYNC_STAGES+1 cycles.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain followed by one history flop for edge comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q          = sync_q[SYNC_STAGES-1];
  assign edge_pulse = q ^ hist_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures clk cycles between edges of the divider strobe.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | disabled, counter cleared, results held
// ST_ALIGN   | waiting for the first edge to phase-align the counter
// ST_MEASURE | counting; each edge reports a half-period, timeout -> ALIGN
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  clock_period_meter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ALL  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  meter_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] prev_half_q;
  logic [CNT_W:0]   full_q;
  logic             have_prev_q;
  logic             meas_valid_q;
  logic             full_valid_q;
  logic             stalled_q;

  logic             sig_edge;
  logic [CNT_W-1:0] half_next;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (bus.sig_in),
    .q          (),
    .edge_pulse (sig_edge)
  );

  // The interval ends on the edge cycle itself, hence +1; saturate at all-ones.
  assign half_next = (cnt_q == CNT_ALL) ? cnt_q : cnt_q + 1'b1;

  // Measurement FSM with counter and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      half_q       <= '0;
      prev_half_q  <= '0;
      full_q       <= '0;
      have_prev_q  <= 1'b0;
      meas_valid_q <= 1'b0;
      full_valid_q <= 1'b0;
      stalled_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!bus.enable) begin
        state_q      <= ST_IDLE;
        cnt_q        <= '0;
        have_prev_q  <= 1'b0;
        full_valid_q <= 1'b0;
        stalled_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q   <= '0;
            state_q <= ST_ALIGN;
          end
          ST_ALIGN: begin
            if (sig_edge) begin
              cnt_q       <= '0;
              have_prev_q <= 1'b0;
              state_q     <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (sig_edge) begin
              half_q       <= half_next;
              prev_half_q  <= half_next;
              meas_valid_q <= 1'b1;
              stalled_q    <= 1'b0;
              cnt_q        <= '0;
              have_prev_q  <= 1'b1;
              if (have_prev_q) begin
                full_q       <= {1'b0, prev_half_q} + {1'b0, half_next};
                full_valid_q <= 1'b1;
              end
            end else if (cnt_q == CNT_LAST) begin
              // Strobe stopped: results hold, re-align before trusting new counts.
              stalled_q    <= 1'b1;
              full_valid_q <= 1'b0;
              have_prev_q  <= 1'b0;
              cnt_q        <= '0;
              state_q      <= ST_ALIGN;
            end else if (cnt_q != CNT_ALL) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.half_period = half_q;
  assign bus.full_period = full_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.full_valid  = full_valid_q;
  assign bus.stalled     = stalled_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with a scoreboard of expected measurements.
module tb_clock_period_meter;
  import clock_period_meter_pkg::*;

  localparam int CNT_W       = 28;
  localparam int TIMEOUT     = 50;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clock_period_meter_if #(.CNT_W(CNT_W)) bus ();

  clock_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int half;
    int full;
    bit fv;
  } exp_t;

  exp_t sb[$];

  int n_asserts = 0;
  int n_fail    = 0;

  bit m_en;
  bit m_aligned;
  bit m_have_prev;
  int m_prev;
  int last_tgl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input int n);
    if (m_aligned && n > TIMEOUT) begin
      m_aligned   = 1'b0;
      m_have_prev = 1'b0;
    end
    if (!m_aligned) begin
      m_aligned = 1'b1;
    end else begin
      sb.push_back('{half: n, full: m_prev + n, fv: m_have_prev});
      m_prev      = n;
      m_have_prev = 1'b1;
    end
  endtask

  task automatic toggle();
    int n;
    n        = cyc - last_tgl;
    last_tgl = cyc;
    bus.sig_in = ~bus.sig_in;
    if (m_en) model_edge(n);
  endtask

  task automatic set_enable(input bit v);
    bus.enable = v;
    m_en       = v;
    if (!v) begin
      m_aligned   = 1'b0;
      m_have_prev = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_half"},  64'(bus.half_period), 64'd0);
    check({tag, "_full"},  64'(bus.full_period), 64'd0);
    check({tag, "_mv"},    64'(bus.meas_valid),  64'd0);
    check({tag, "_fv"},    64'(bus.full_valid),  64'd0);
    check({tag, "_stall"}, 64'(bus.stalled),     64'd0);
  endtask

  // Scoreboard consumer: every meas_valid pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.meas_valid === 1'b1) begin
      check("pulse_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_half", 64'(bus.half_period), 64'(e.half));
        check("sb_full_valid", 64'(bus.full_valid), 64'(e.fv));
        if (e.fv) check("sb_full", 64'(bus.full_period), 64'(e.full));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sig_in  = 1'b0;
    bus.enable  = 1'b0;
    rst_n       = 1'b0;
    m_en        = 1'b0;
    m_aligned   = 1'b0;
    m_have_prev = 1'b0;
    m_prev      = 0;
    last_tgl    = 0;

    // Reset held while the strobe moves.
    tick(2);
    repeat (4) begin
      bus.sig_in = ~bus.sig_in;
      tick(2);
    end
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(10);
    check_all_zero("idle_after_reset");

    // Square wave, 10 cycles per half.
    set_enable(1'b1);
    tick(3);
    toggle();
    repeat (6) begin
      tick(10);
      toggle();
    end
    tick(5);
    check("sq_half", 64'(bus.half_period), 64'd10);
    check("sq_full", 64'(bus.full_period), 64'd20);
    check("sq_fv",   64'(bus.full_valid),  64'd1);

    // Asymmetric wave, 7 high / 13 low.
    tick(2);
    toggle();
    repeat (3) begin
      tick(13);
      toggle();
      tick(7);
      toggle();
    end
    tick(4);
    check("asym_half", 64'(bus.half_period), 64'd7);
    check("asym_full", 64'(bus.full_period), 64'd20);
    tick(6);
    toggle();
    tick(10);
    toggle();

    // Freeze the strobe and watch for the timeout.
    tick(52);
    check("stall_early", 64'(bus.stalled), 64'd0);
    tick(1);
    check("stall_set",   64'(bus.stalled),     64'd1);
    check("stall_half",  64'(bus.half_period), 64'd10);
    check("stall_full",  64'(bus.full_period), 64'd20);
    check("stall_fv",    64'(bus.full_valid),  64'd0);
    check("stall_mv",    64'(bus.meas_valid),  64'd0);

    // Restart: stalled clears only after a full interval is measured.
    tick(7);
    toggle();
    tick(4);
    check("restart_align_stall", 64'(bus.stalled), 64'd1);
    tick(6);
    toggle();
    tick(4);
    check("restart_meas_stall", 64'(bus.stalled),     64'd0);
    check("restart_meas_half",  64'(bus.half_period), 64'd10);
    tick(6);
    toggle();
    repeat (2) begin
      tick(10);
      toggle();
    end

    // Disable mid-interval, strobe moves while idle, then re-enable.
    tick(5);
    set_enable(1'b0);
    tick(1);
    check("dis_mv",    64'(bus.meas_valid),  64'd0);
    check("dis_stall", 64'(bus.stalled),     64'd0);
    check("dis_fv",    64'(bus.full_valid),  64'd0);
    check("dis_half",  64'(bus.half_period), 64'd10);
    check("dis_full",  64'(bus.full_period), 64'd20);
    toggle();
    tick(6);
    set_enable(1'b1);
    tick(3);
    toggle();
    repeat (4) begin
      tick(12);
      toggle();
    end
    tick(4);
    check("reen_half", 64'(bus.half_period), 64'd12);
    check("reen_full", 64'(bus.full_period), 64'd24);
    check("reen_fv",   64'(bus.full_valid),  64'd1);

    // Strobe toggling every cycle.
    tick(6);
    toggle();
    repeat (8) begin
      tick(1);
      toggle();
    end
    check("b2b_mv",   64'(bus.meas_valid),  64'd1);
    check("b2b_half", 64'(bus.half_period), 64'd1);
    check("b2b_full", 64'(bus.full_period), 64'd2);

    // Edge landing on the timeout cycle wins.
    tick(50);
    toggle();
    tick(4);
    check("coinc_stall", 64'(bus.stalled),     64'd0);
    check("coinc_half",  64'(bus.half_period), 64'd50);
    check("coinc_full",  64'(bus.full_period), 64'd51);
    check("coinc_fv",    64'(bus.full_valid),  64'd1);

    // Reset in the middle of measuring.
    tick(6);
    toggle();
    tick(5);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    set_enable(1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
